// File: rtl/template_feeder_pkg.sv
// template_feeder_pkg: shared constants, state/wave encodings and arithmetic helpers
// for the template feeder and the matcher it drives.
package template_feeder_pkg;
  localparam int FRAME_LEN   = 256;
  localparam int DIFF_OFFSET = 128;
  localparam logic [7:0] SQR_HI = 8'd255;
  localparam logic [7:0] SQR_LO = 8'd0;
  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2} state_t;
  typedef enum logic [1:0] {TRI = 2'd0, SQR = 2'd1, SIN = 2'd2} wave_t;
  // Biased first difference, saturated to the unsigned byte range.
  function automatic logic [7:0] sat_diff(input logic [7:0] cur, input logic [7:0] prev);
    logic signed [9:0] d;
    d = $signed({2'b00, cur}) - $signed({2'b00, prev}) + 10'(DIFF_OFFSET);
    return d < 0 ? 8'd0 : d > 10'sd255 ? 8'd255 : d[7:0];
  endfunction
  function automatic logic [7:0] tri_val(input logic [7:0] k);
    return k[7] ? 8'(9'd510 - {k, 1'b0}) : {k[6:0], 1'b0};
  endfunction
  // Quadrants 1 and 3 read the quarter-wave ROM mirrored (64-m).
  function automatic logic [6:0] sin_index(input logic [7:0] k);
    return k[6] ? 7'd64 - {1'b0, k[5:0]} : {1'b0, k[5:0]};
  endfunction
  // Second half-period sits below mid-scale.
  function automatic logic [7:0] sin_val(input logic [7:0] k, input logic [6:0] q);
    return k[7] ? 8'd128 - {1'b0, q} : 8'd128 + {1'b0, q};
  endfunction
endpackage

// File: rtl/template_feeder_sin_quarter_rom.sv
// sin_quarter_rom: combinational quarter-wave sine table, q = round(127*sin(pi*idx/128)).
// Ports: idx (0..64 table index), q (magnitude 0..127).
module sin_quarter_rom (
  input  logic [6:0] idx,
  output logic [6:0] q
);
  always_comb begin
    q = 7'd0;
    case (idx)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
  end
endmodule

// File: rtl/template_feeder.sv
// template_feeder: streams one 256-sample frame with phase-aligned templates to the matcher.
// Ports: clk, rst_n (sync, active low); start, sample_valid, sample_in (frame input);
// busy, frame_done, match_rst_n (control); wave_valid, wave_in, dwave_in and the
// tri/sqr/sin templates plus dtri/dsin derivative templates (matcher bus).
module template_feeder
  import template_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sample_valid,
  input  logic [7:0] sample_in,
  output logic       busy,
  output logic       frame_done,
  output logic       match_rst_n,
  output logic       wave_valid,
  output logic [7:0] wave_in,
  output logic [7:0] dwave_in,
  output logic [7:0] tri_template,
  output logic [7:0] sqr_template,
  output logic [7:0] sin_template,
  output logic [7:0] dtri_template,
  output logic [7:0] dsin_template
);
  state_t state, state_nx;
  logic [7:0] k, kp, prev_sample;
  logic [6:0] q_cur, q_prv;
  logic accept, last;
  assign accept = state == RUN && sample_valid;
  assign last = k == 8'(FRAME_LEN - 1);
  assign kp = k - 8'd1;
  assign busy = state != IDLE;
  assign match_rst_n = state != CLR;
  sin_quarter_rom u_rom_cur (.idx(sin_index(k)),  .q(q_cur));
  sin_quarter_rom u_rom_prv (.idx(sin_index(kp)), .q(q_prv));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CLR : IDLE;
      CLR:     state_nx = RUN;
      RUN:     state_nx = accept && last ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= 8'd0;
      prev_sample   <= 8'd0;
      wave_valid    <= 1'b0;
      frame_done    <= 1'b0;
      wave_in       <= 8'd0;
      dwave_in      <= 8'd0;
      tri_template  <= 8'd0;
      sqr_template  <= 8'd0;
      sin_template  <= 8'd0;
      dtri_template <= 8'd0;
      dsin_template <= 8'd0;
    end else begin
      state      <= state_nx;
      wave_valid <= accept;
      frame_done <= accept && last;
      if (state == CLR) k <= 8'd0;
      if (accept) begin
        k             <= k + 8'd1;
        prev_sample   <= sample_in;
        wave_in       <= sample_in;
        // First sample of a frame has no predecessor: report zero slope.
        dwave_in      <= sat_diff(sample_in, k == 8'd0 ? sample_in : prev_sample);
        tri_template  <= tri_val(k);
        sqr_template  <= k[7] ? SQR_LO : SQR_HI;
        sin_template  <= sin_val(k, q_cur);
        dtri_template <= sat_diff(tri_val(k), tri_val(kp));
        dsin_template <= sat_diff(sin_val(k, q_cur), sin_val(kp, q_prv));
      end
    end
  end
endmodule

// File: tb/tb_template_feeder.sv
// tb_template_feeder: directed self-checking bench for template_feeder.
module tb_template_feeder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sample_valid = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic busy, frame_done, match_rst_n, wave_valid;
  logic [7:0] wave_in, dwave_in, tri_template, sqr_template, sin_template, dtri_template, dsin_template;
  int n_checks = 0, n_fail = 0;

  template_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid), .sample_in(sample_in),
    .busy(busy), .frame_done(frame_done), .match_rst_n(match_rst_n), .wave_valid(wave_valid),
    .wave_in(wave_in), .dwave_in(dwave_in), .tri_template(tri_template), .sqr_template(sqr_template),
    .sin_template(sin_template), .dtri_template(dtri_template), .dsin_template(dsin_template)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if ({busy, frame_done, match_rst_n, wave_valid} !== 4'b0010) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: busy/done/mrst/valid got %b expected 0010", p, {busy, frame_done, match_rst_n, wave_valid});
      end
      n_checks++;
      if ({wave_in, dwave_in, tri_template, sqr_template, sin_template, dtri_template, dsin_template} !== 56'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h expected 0", p, {wave_in, dwave_in, tri_template, sqr_template, sin_template, dtri_template, dsin_template});
      end
      rst_n = 1'b1;
      repeat (2) tick();
    end
  endtask

  task automatic test_handshake;
    start = 1'b1; sample_valid = 1'b1; sample_in = 8'd77;
    tick();
    n_checks++;
    if ({match_rst_n, busy, wave_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL clr_cycle: mrst/busy/valid got %b expected 010", {match_rst_n, busy, wave_valid});
    end
    start = 1'b0;
    tick();
    n_checks++;
    if ({match_rst_n, busy, wave_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL run_entry: mrst/busy/valid got %b expected 110", {match_rst_n, busy, wave_valid});
    end
  endtask

  task automatic test_ramp_frame;
    logic [7:0] e_tri, e_sqr, e_dtri, e_dw;
    for (int i = 0; i < 256; i++) begin
      sample_valid = 1'b1; sample_in = 8'(i);
      tick();
      e_tri  = i < 128 ? 8'(2 * i) : 8'(510 - 2 * i);
      e_sqr  = i < 128 ? 8'd255 : 8'd0;
      e_dtri = (i == 0 || i == 128) ? 8'd128 : i < 128 ? 8'd130 : 8'd126;
      e_dw   = i == 0 ? 8'd128 : 8'd129;
      n_checks++;
      if ({wave_valid, wave_in, dwave_in} !== {1'b1, 8'(i), e_dw}) begin
        n_fail++;
        $display("FAIL ramp_wave k=%0d: valid=%0d wave=%0d dwave=%0d expected 1 %0d %0d", i, wave_valid, wave_in, dwave_in, i, e_dw);
      end
      n_checks++;
      if ({tri_template, sqr_template, dtri_template} !== {e_tri, e_sqr, e_dtri}) begin
        n_fail++;
        $display("FAIL ramp_tpl k=%0d: tri=%0d sqr=%0d dtri=%0d expected %0d %0d %0d", i, tri_template, sqr_template, dtri_template, e_tri, e_sqr, e_dtri);
      end
      n_checks++;
      if ({frame_done, busy} !== {i == 255, i != 255}) begin
        n_fail++;
        $display("FAIL ramp_ctrl k=%0d: done=%0d busy=%0d expected %0d %0d", i, frame_done, busy, i == 255, i != 255);
      end
      if (i % 64 == 0) begin
        n_checks++;
        if (sin_template !== (i == 64 ? 8'd255 : i == 192 ? 8'd1 : 8'd128)) begin
          n_fail++;
          $display("FAIL ramp_sin k=%0d: got %0d", i, sin_template);
        end
      end
      if (i == 0 || i == 128) begin
        n_checks++;
        if (dsin_template !== (i == 0 ? 8'd131 : 8'd125)) begin
          n_fail++;
          $display("FAIL ramp_dsin k=%0d: got %0d expected %0d", i, dsin_template, i == 0 ? 131 : 125);
        end
      end
    end
    sample_valid = 1'b0;
    tick();
    n_checks++;
    if ({wave_valid, frame_done, busy, wave_in} !== {3'b000, 8'd255}) begin
      n_fail++;
      $display("FAIL ramp_after: valid=%0d done=%0d busy=%0d wave=%0d expected 0 0 0 255", wave_valid, frame_done, busy, wave_in);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] smp [3] = '{8'd0, 8'd255, 8'd0};
    logic [7:0] exp_d [3] = '{8'd128, 8'd255, 8'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; sample_in = smp[i];
      tick();
      n_checks++;
      if ({wave_valid, dwave_in} !== {1'b1, exp_d[i]}) begin
        n_fail++;
        $display("FAIL sat[%0d]: valid=%0d dwave=%0d expected 1 %0d", i, wave_valid, dwave_in, exp_d[i]);
      end
    end
  endtask

  task automatic test_gapped_abort;
    int dones;
    for (int j = 3; j < 100; j++) begin
      sample_valid = 1'b1; sample_in = 8'(j);
      tick();
      n_checks++;
      if ({wave_valid, frame_done, wave_in, tri_template, dwave_in} !== {2'b10, 8'(j), 8'(2 * j), (j == 3 ? 8'd131 : 8'd129)}) begin
        n_fail++;
        $display("FAIL gap_acc k=%0d: valid=%0d done=%0d wave=%0d tri=%0d dwave=%0d", j, wave_valid, frame_done, wave_in, tri_template, dwave_in);
      end
      sample_valid = 1'b0; sample_in = 8'hAA;
      tick();
      n_checks++;
      if ({wave_valid, wave_in, tri_template} !== {1'b0, 8'(j), 8'(2 * j)}) begin
        n_fail++;
        $display("FAIL gap_hold k=%0d: valid=%0d wave=%0d tri=%0d expected 0 %0d %0d", j, wave_valid, wave_in, tri_template, j, 2 * j);
      end
    end
    rst_n = 1'b0; start = 1'b1;
    tick();
    n_checks++;
    if ({busy, match_rst_n, wave_valid, frame_done, wave_in} !== {4'b0100, 8'd0}) begin
      n_fail++;
      $display("FAIL abort: busy=%0d mrst=%0d valid=%0d done=%0d wave=%0d expected 0 1 0 0 0", busy, match_rst_n, wave_valid, frame_done, wave_in);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({match_rst_n, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_clr: mrst=%0d busy=%0d expected 0 1", match_rst_n, busy);
    end
    start = 1'b0;
    tick();
    dones = 0;
    for (int i = 0; i < 256; i++) begin
      sample_valid = 1'b1; sample_in = 8'(255 - i);
      tick();
      dones += int'(frame_done);
      n_checks++;
      if ({wave_valid, wave_in, dwave_in, tri_template} !== {1'b1, 8'(255 - i), (i == 0 ? 8'd128 : 8'd127), (i < 128 ? 8'(2 * i) : 8'(510 - 2 * i))}) begin
        n_fail++;
        $display("FAIL restart k=%0d: valid=%0d wave=%0d dwave=%0d tri=%0d", i, wave_valid, wave_in, dwave_in, tri_template);
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (dones !== 1 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: count=%0d last=%0d expected 1 1", dones, frame_done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_ramp_frame();
    test_saturation();
    test_gapped_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
